ibex_pext_mac_acc: RTL and testbench
====================================

IBEX_PEXT_MAC_ACC -- requirements
Module: ibex_pext_mac_acc

Interface
REQ-001 SHALL use one clock and asynchronous active-low reset: clk_i, rst_ni.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk_i  in  1  clock
- rst_ni  in  1  async reset, active low
- valid_i  in  1  upstream product valid
- ready_o  out  1  block can accept a product
- prod_i  in  48  signed 32x16 product from the P-ext multiplier
- rd_val_i  in  32  destination register value (accumulate addend)
- op_i  in  pext_mac_op_e  SMMWB, SMMWB_U, KMMAWB, KMMAWB_U
- result_o  out  32  final word to writeback
- valid_o  out  1  result_o valid
- ready_i  in  1  writeback accepts result
- vxsat_clr_i  in  1  clear sticky saturation flag
- vxsat_o  out  1  sticky saturation (OV) flag

Function
REQ-003 SHALL accept a transfer when valid_i && ready_o; ready_o SHALL be 1 only in IDLE.
REQ-004 SHALL register prod_i, rd_val_i and op_i on acceptance; later input changes SHALL not affect the result.
REQ-005 SHALL implement the FSM IDLE -> SHIFT -> ACC -> DONE -> IDLE; DONE -> IDLE requires ready_i; all other transitions take one cycle each.
REQ-006 SHIFT: hi = prod[47:16]; for the _U ops, hi = prod[47:16] + prod[15] (round half up); this addition cannot overflow and SHALL NOT be saturated.
REQ-007 ACC: for KMMAWB/KMMAWB_U, form the 33-bit signed sum hi + rd_val; for SMMWB/SMMWB_U, pass hi unchanged.
REQ-008 Saturation SHALL clamp the sum to 0x7FFFFFFF when it exceeds 2^31-1 and to 0x80000000 when it is below -2^31.
REQ-009 valid_o SHALL be 1 exactly in DONE; latency from acceptance to valid_o SHALL be 3 cycles.
REQ-010 result_o SHALL hold stable while valid_o && !ready_i.
REQ-011 vxsat_o SHALL be sticky: set in the cycle after ACC saturates, cleared by vxsat_clr_i; simultaneous set and clear SHALL leave it set.
REQ-012 valid_i outside IDLE SHALL be ignored; no queuing.

Reset
REQ-013 On rst_ni low, at any state including mid-operation: state = IDLE, result_o = 0, valid_o = 0, vxsat_o = 0, ready_o = 1 after release; any in-flight operation SHALL be discarded.

Configuration
REQ-014 SHALL provide the macro PEXT_MAC_ROUND_EN.
- Defined: SMMWB_U and KMMAWB_U apply rounding per REQ-006.
- Undefined: the _U ops SHALL behave identically to SMMWB/KMMAWB, and the rounding adder SHALL be absent.

Structure
REQ-015 The pext_mac_op_e enum and the saturation constants (SAT_MAX32, SAT_MIN32) SHALL live in ibex_pkg_pext.
REQ-016 A combinational sub-module ibex_pext_sat32 SHALL perform the 33-to-32-bit clamp and produce the overflow flag.

Verification
REQ-017 The bench SHALL cover these scenarios:
- SMMWB, prod=48'h0000_1234_5678 -> result_o=32'h0000_1234 3 cycles after acceptance; vxsat_o stays 0.
- SMMWB_U (PEXT_MAC_ROUND_EN), prod=48'h0000_1234_8000 -> 32'h0000_1235; without the macro -> 32'h0000_1234.
- KMMAWB, prod=48'h4000_0000_0000, rd_val=32'h7FFF_FFF0 -> 32'h7FFF_FFFF, vxsat_o=1; vxsat_clr_i pulse -> 0.
- KMMAWB, prod=48'hC000_0000_0000, rd_val=32'h8000_0010 -> 32'h8000_0000, vxsat_o=1.
- Backpressure: ready_i=0 for 5 cycles in DONE -> valid_o, result_o stable, ready_o=0, extra valid_i ignored; ready_i=1 -> IDLE next cycle.
- rst_ni low during ACC -> valid_o=0, vxsat_o=0, result_o=0; next accepted op completes correctly.

Source files
------------

// File: rtl/ibex_pkg_pext.sv
// ibex_pkg_pext
//   Shared types and constants for the P-extension multiply-accumulate
//   post-processing path. It holds the MAC op encoding, the FSM state
//   encoding, the 32-bit saturation bounds and small op-decode helpers.
//   Optional feature macro used by the importers: PEXT_MAC_ROUND_EN.
package ibex_pkg_pext;

  typedef enum logic [1:0] {
    PEXT_SMMWB    = 2'd0,
    PEXT_SMMWB_U  = 2'd1,
    PEXT_KMMAWB   = 2'd2,
    PEXT_KMMAWB_U = 2'd3
  } pext_mac_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ACC   = 2'd2,
    ST_DONE  = 2'd3
  } mac_state_e;

  localparam logic [31:0] SAT_MAX32 = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN32 = 32'h8000_0000;

  // KMMAWB variants add the destination register; SMMWB variants do not.
  function automatic logic is_acc_op(input pext_mac_op_e op);
    return (op == PEXT_KMMAWB) || (op == PEXT_KMMAWB_U);
  endfunction

  // The _U variants round the high word half-up when rounding is built in.
  function automatic logic is_round_op(input pext_mac_op_e op);
    return (op == PEXT_SMMWB_U) || (op == PEXT_KMMAWB_U);
  endfunction

endpackage

// File: rtl/ibex_pext_sat32.sv
// ibex_pext_sat32
//   Combinational clamp of a 33-bit two's-complement sum into 32 bits.
//   Ports:
//     sum  in  33  signed sum to clamp
//     res  out 32  clamped result
//     ovf  out 1   sum was outside the 32-bit signed range
module ibex_pext_sat32
  import ibex_pkg_pext::*;
(
  input  logic [32:0] sum,
  output logic [31:0] res,
  output logic        ovf
);

  // A 33-bit sum fits in 32 bits exactly when its two top bits agree.
  // The top bit then tells which bound was crossed.
  always_comb begin
    ovf = sum[32] ^ sum[31];
    res = sum[31:0];
    if (ovf) begin
      res = sum[32] ? SAT_MIN32 : SAT_MAX32;
    end
  end

endmodule

// File: rtl/ibex_pext_mac_acc.sv
// ibex_pext_mac_acc
//   Post-multiplier stage for SMMWB/KMMAWB (and _U rounding variants).
//   It takes the 48-bit signed 32x16 product, keeps the high word, optionally
//   rounds, optionally adds rd and saturates to 32 bits. It keeps a sticky
//   saturation flag.
//   Optional feature macro: PEXT_MAC_ROUND_EN (enables _U rounding; when
//   undefined the _U ops behave like the plain ops and no rounding adder
//   exists).
//   Ports:
//     clk_i, rst_ni      clock, async active-low reset
//     valid_i / ready_o  upstream product handshake
//     prod_i             48-bit signed product
//     rd_val_i           32-bit accumulate addend
//     op_i               pext_mac_op_e operation
//     result_o           32-bit writeback word
//     valid_o / ready_i  writeback handshake
//     vxsat_clr_i        clears the sticky flag
//     vxsat_o            sticky saturation flag
//
//   Handshake: a transfer happens on a rising clk edge where valid==1 and
//   ready==1 on the same channel. Upstream: ready_o is high only in IDLE, and
//   valid_i in any other state is ignored (nothing is queued). Downstream:
//   valid_o is high only in DONE, and result_o holds until ready_i is seen.
module ibex_pext_mac_acc
  import ibex_pkg_pext::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [47:0]  prod_i,
  input  logic [31:0]  rd_val_i,
  input  pext_mac_op_e op_i,
  output logic [31:0]  result_o,
  output logic         valid_o,
  input  logic         ready_i,
  input  logic         vxsat_clr_i,
  output logic         vxsat_o
);

  mac_state_e   state_q, state_d;
  logic [47:0]  prod_q;
  logic [31:0]  rd_q;
  pext_mac_op_e op_q;
  logic [31:0]  hi_q;
  logic [31:0]  hi_d;
  logic [32:0]  sum_d;
  logic [31:0]  sat_res;
  logic         sat_ovf;
  logic [31:0]  result_q;
  logic         vxsat_q;
  logic         accept;

  assign accept = valid_i && (state_q == ST_IDLE);

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_d = ST_SHIFT;
      end
      ST_SHIFT: state_d = ST_ACC;
      ST_ACC:   state_d = ST_DONE;
      ST_DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
`ifdef PEXT_MAC_ROUND_EN
  // prod is a 32x16 product, so |prod[47:16]| stays well below 2^31 and the
  // +1 cannot wrap.
  assign hi_d = prod_q[47:16] + {31'b0, is_round_op(op_q) & prod_q[15]};
`else
  assign hi_d = prod_q[47:16];
  logic unused_prod_lsb;
  assign unused_prod_lsb = ^prod_q[15:0];
`endif

  // Sign-extend both operands to 33 bits so the saturator sees the true sum.
  always_comb begin
    sum_d = {hi_q[31], hi_q};
    if (is_acc_op(op_q)) begin
      sum_d = {hi_q[31], hi_q} + {rd_q[31], rd_q};
    end
  end

  ibex_pext_sat32 u_sat32 (
    .sum (sum_d),
    .res (sat_res),
    .ovf (sat_ovf)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q   <= '0;
      rd_q     <= '0;
      op_q     <= PEXT_SMMWB;
      hi_q     <= '0;
      result_q <= '0;
      vxsat_q  <= 1'b0;
    end else begin
      if (accept) begin
        prod_q <= prod_i;
        rd_q   <= rd_val_i;
        op_q   <= op_i;
      end
      if (state_q == ST_SHIFT) begin
        hi_q <= hi_d;
      end
      if (state_q == ST_ACC) begin
        result_q <= sat_res;
      end
      // Set wins over clear in the same cycle.
      vxsat_q <= (vxsat_q & ~vxsat_clr_i) | ((state_q == ST_ACC) & sat_ovf);
    end
  end

  assign result_o = result_q;
  assign vxsat_o  = vxsat_q;

endmodule

// File: tb/tb_ibex_pext_mac_acc.sv
// tb_ibex_pext_mac_acc
//   Table-driven directed bench for ibex_pext_mac_acc plus hand-written
//   sequences for sticky flag, backpressure and mid-operation reset.
//   Honours PEXT_MAC_ROUND_EN for the expected values of the _U ops.
module tb_ibex_pext_mac_acc;
  import ibex_pkg_pext::*;

  logic         clk;
  logic         rst_n;
  logic         valid_i;
  logic         ready_o;
  logic [47:0]  prod_i;
  logic [31:0]  rd_val_i;
  pext_mac_op_e op_i;
  logic [31:0]  result_o;
  logic         valid_o;
  logic         ready_i;
  logic         vxsat_clr_i;
  logic         vxsat_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ibex_pext_mac_acc dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .prod_i      (prod_i),
    .rd_val_i    (rd_val_i),
    .op_i        (op_i),
    .result_o    (result_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .vxsat_clr_i (vxsat_clr_i),
    .vxsat_o     (vxsat_o)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

`ifdef PEXT_MAC_ROUND_EN
  localparam logic [31:0] EXP_SMMWB_U  = 32'h0000_1235;
  localparam logic [31:0] EXP_KMMAWB_U = 32'h0000_0013;
  localparam logic [31:0] EXP_NEG_U    = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_SMMWB_U  = 32'h0000_1234;
  localparam logic [31:0] EXP_KMMAWB_U = 32'h0000_0012;
  localparam logic [31:0] EXP_NEG_U    = 32'hFFFF_FFFF;
`endif

  typedef struct {
    pext_mac_op_e op;
    logic [47:0]  prod;
    logic [31:0]  rd;
    logic [31:0]  exp_res;
    logic         exp_vx;
  } vec_t;

  vec_t vecs[10];

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_op(input pext_mac_op_e op, input logic [47:0] prod, input logic [31:0] rd);
    int n;
    n = 0;
    while (!ready_o && n < 20) begin
      tick();
      n++;
    end
    check("ready_before_send", {31'b0, ready_o}, 32'd1);
    valid_i  = 1'b1;
    op_i     = op;
    prod_i   = prod;
    rd_val_i = rd;
    tick();
    // Scramble inputs after acceptance; the result must not follow them.
    valid_i  = 1'b0;
    op_i     = PEXT_KMMAWB_U;
    prod_i   = 48'h3A5A_5A5A_FFFF;
    rd_val_i = 32'h1357_9BDF;
  endtask

  // Returns cycles from the accepting edge until valid_o is seen.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!valid_o && lat < 10) begin
      tick();
      lat++;
    end
  endtask

  task automatic pulse_clr();
    vxsat_clr_i = 1'b1;
    tick();
    vxsat_clr_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    vecs[0] = '{PEXT_SMMWB,    48'h0000_1234_5678, 32'h0000_0000, 32'h0000_1234, 1'b0};
    vecs[1] = '{PEXT_SMMWB_U,  48'h0000_1234_8000, 32'h0000_0000, EXP_SMMWB_U,   1'b0};
    vecs[2] = '{PEXT_KMMAWB,   48'h4000_0000_0000, 32'h7FFF_FFF0, 32'h7FFF_FFFF, 1'b1};
    vecs[3] = '{PEXT_KMMAWB,   48'hC000_0000_0000, 32'h8000_0010, 32'h8000_0000, 1'b1};
    vecs[4] = '{PEXT_KMMAWB,   48'h0000_0001_0000, 32'h0000_0005, 32'h0000_0006, 1'b0};
    vecs[5] = '{PEXT_SMMWB,    48'hFFFF_FFFF_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[6] = '{PEXT_KMMAWB_U, 48'h0000_0010_8000, 32'h0000_0002, EXP_KMMAWB_U,  1'b0};
    vecs[7] = '{PEXT_SMMWB_U,  48'hFFFF_FFFF_FFFF, 32'h0000_0000, EXP_NEG_U,     1'b0};
    vecs[8] = '{PEXT_KMMAWB,   48'h3FFF_FFFF_0000, 32'h4000_0000, 32'h7FFF_FFFF, 1'b0};
    vecs[9] = '{PEXT_KMMAWB,   48'hC000_0000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0};

    // clock/reset
    rst_n       = 1'b0;
    valid_i     = 1'b0;
    prod_i      = '0;
    rd_val_i    = '0;
    op_i        = PEXT_SMMWB;
    ready_i     = 1'b1;
    vxsat_clr_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("reset_ready",  {31'b0, ready_o}, 32'd1);
    check("reset_valid",  {31'b0, valid_o}, 32'd0);
    check("reset_result", result_o,         32'd0);
    check("reset_vxsat",  {31'b0, vxsat_o}, 32'd0);

    // table-driven vectors
    for (int i = 0; i < 10; i++) begin
      pulse_clr();
      send_op(vecs[i].op, vecs[i].prod, vecs[i].rd);
      wait_valid(lat);
      check($sformatf("v%0d_latency", i), lat, 32'd3);
      check($sformatf("v%0d_result", i), result_o, vecs[i].exp_res);
      check($sformatf("v%0d_vxsat", i), {31'b0, vxsat_o}, {31'b0, vecs[i].exp_vx});
      tick();
      check($sformatf("v%0d_idle_ready", i), {31'b0, ready_o}, 32'd1);
      check($sformatf("v%0d_idle_valid", i), {31'b0, valid_o}, 32'd0);
    end

    // sticky flag set then cleared
    pulse_clr();
    send_op(PEXT_KMMAWB, 48'h4000_0000_0000, 32'h7FFF_FFF0);
    wait_valid(lat);
    check("sticky_set", {31'b0, vxsat_o}, 32'd1);
    tick();
    repeat (2) tick();
    check("sticky_held", {31'b0, vxsat_o}, 32'd1);
    pulse_clr();
    check("sticky_cleared", {31'b0, vxsat_o}, 32'd0);

    // clear asserted on the same edge that saturates: set wins
    send_op(PEXT_KMMAWB, 48'hC000_0000_0000, 32'h8000_0010);
    tick();
    vxsat_clr_i = 1'b1;
    tick();
    vxsat_clr_i = 1'b0;
    check("set_beats_clear", {31'b0, vxsat_o}, 32'd1);
    check("set_beats_clear_valid", {31'b0, valid_o}, 32'd1);
    tick();

    // backpressure in DONE with extra valid_i
    ready_i = 1'b0;
    send_op(PEXT_KMMAWB, 48'h0000_0001_0000, 32'h0000_0005);
    wait_valid(lat);
    check("bp_latency", lat, 32'd3);
    for (int c = 0; c < 5; c++) begin
      valid_i = 1'b1;
      op_i    = PEXT_SMMWB;
      prod_i  = 48'h0000_7777_0000 + 48'(c);
      check($sformatf("bp%0d_valid", c),  {31'b0, valid_o}, 32'd1);
      check($sformatf("bp%0d_result", c), result_o,         32'h0000_0006);
      check($sformatf("bp%0d_ready", c),  {31'b0, ready_o}, 32'd0);
      tick();
    end
    valid_i = 1'b0;
    check("bp_still_valid", {31'b0, valid_o}, 32'd1);
    ready_i = 1'b1;
    tick();
    check("bp_release_ready", {31'b0, ready_o}, 32'd1);
    check("bp_release_valid", {31'b0, valid_o}, 32'd0);
    repeat (4) tick();
    check("bp_no_queue", {31'b0, valid_o}, 32'd0);

    // reset while in ACC discards the operation
    send_op(PEXT_KMMAWB, 48'h4000_0000_0000, 32'h7FFF_FFF0);
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_acc_valid",  {31'b0, valid_o}, 32'd0);
    check("rst_acc_vxsat",  {31'b0, vxsat_o}, 32'd0);
    check("rst_acc_result", result_o,         32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_release_ready", {31'b0, ready_o}, 32'd1);
    repeat (4) tick();
    check("rst_discarded_valid", {31'b0, valid_o}, 32'd0);
    check("rst_discarded_vxsat", {31'b0, vxsat_o}, 32'd0);
    send_op(PEXT_SMMWB, 48'h0000_1234_5678, 32'h0000_0000);
    wait_valid(lat);
    check("post_rst_latency", lat, 32'd3);
    check("post_rst_result", result_o, 32'h0000_1234);
    check("post_rst_vxsat", {31'b0, vxsat_o}, 32'd0);
    tick();

    // report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
